score_bcd_counter: RTL and testbench
====================================

Name: score_bcd_counter

Overview:
- Snake-game score keeper; sits directly upstream of the per-digit 7-segment hex decoders.
- Counts food-eaten events as a multi-digit BCD score and tracks the session high score.
- Presents either the current score or the high score as packed 4-bit BCD nibbles, one per display digit.
- Small game-phase FSM gates counting and latches the high score at game over.

Parameters:
- NUM_DIGITS, 4, number of BCD digits in score and high score (1..8).
- POINTS, 1, BCD points added per eat pulse (1..9).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears all state including high score.
- start  input  1  one-cycle pulse; begins a new game.
- eat  input  1  one-cycle pulse; snake ate food.
- game_over  input  1  one-cycle pulse; snake died.
- show_high  input  1  level; 1 = display high score, 0 = display current score.
- digits  output  NUM_DIGITS*4  packed BCD nibbles; digit 0 (least significant) in bits [3:0]; each nibble feeds one hex decoder.
- playing  output  1  high while FSM is in PLAYING.
- new_high  output  1  high in OVER when the last game set a new high score.

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset state: FSM=IDLE; score=0; high=0; digits=0; playing=0; new_high=0.
- FSM states are IDLE, PLAYING and OVER.
  - IDLE --start--> PLAYING: score cleared to 0 on the same edge.
  - PLAYING --game_over--> OVER.
  - PLAYING --start--> PLAYING: restart; score cleared; high unchanged.
  - OVER --start--> PLAYING: score cleared; new_high cleared.
  - All other inputs hold the current state.
- Counting:
  - eat is honoured only in PLAYING with game_over=0 and start=0.
  - score += POINTS in BCD, with a decimal carry ripple through all NUM_DIGITS in one cycle.
  - Each nibble stays in 0..9 at all times.
- Saturation: if the addition would exceed the all-9s value, score = all-9s (e.g. 9999 for 4 digits). The score never wraps.
- Simultaneous events:
  - game_over has priority over eat; the eat is dropped.
  - start has priority over eat and game_over in every state.
  - reset overrides everything.
- High-score update: on the PLAYING->OVER edge:
  - if score > high (decimal compare, MSD first), then high <= score and new_high <= 1;
  - otherwise new_high <= 0.
  - Equal scores do not set new_high.
- eat in IDLE or OVER: ignored; score frozen.
- game_over in IDLE or OVER: ignored; no high update.
- digits:
  - Registered output, mux of high (show_high=1) or score (show_high=0).
  - 1-cycle latency from an eat edge or a show_high change to a digits change.
- playing and new_high are registered and reflect the FSM state after the edge.
- Reset mid-game: next edge returns everything to reset values; the high score is lost.

Test Plan:
- Reset then idle: assert reset 2 cycles, drive eat pulses in IDLE -> digits=0x0000, playing=0, new_high=0.
- Basic count and carry: start, then 10 eat pulses (POINTS=1) -> digits=0x0010; after 99 total eats -> 0x0099; 1 more -> 0x0100. digits updates one cycle after each eat.
- Saturation: POINTS=9, preload by 1111 eats -> digits=0x9999; 1 more eat -> still 0x9999, no wrap to 0x0008.
- High-score flow:
  - Game 1: 25 eats, game_over -> new_high=1; show_high=1 gives 0x0025.
  - Game 2: start, 25 eats, game_over -> new_high=0, high=0x0025.
  - Game 3: start, 30 eats, game_over -> new_high=1, high=0x0030.
- Simultaneous pulses:
  - score 0x0007; eat+game_over same cycle -> OVER with score 0x0007.
  - start+eat same cycle from OVER -> PLAYING with score 0x0000.
- Reset mid-game: score 0x0042, high 0x0030, assert reset one cycle -> score=0, high=0, FSM IDLE, digits=0x0000 next cycle.

Source files
------------

// File: rtl/score_bcd_counter_if.sv
// Game-event inputs and display outputs of the score keeper.
// The master drives the game events; the slave is the score_bcd_counter.
interface score_bcd_counter_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    start;
  logic                    eat;
  logic                    game_over;
  logic                    show_high;
  logic [NUM_DIGITS*4-1:0] digits;
  logic                    playing;
  logic                    new_high;

  modport master (
    output start, eat, game_over, show_high,
    input  digits, playing, new_high
  );

  modport slave (
    input  start, eat, game_over, show_high,
    output digits, playing, new_high
  );
endinterface

// File: rtl/score_bcd_counter.sv
// Snake score keeper: saturating BCD score, session high score, registered digit mux.
// Outputs are registered and show the state after each edge; there is no backpressure.
module score_bcd_counter #(
  parameter int NUM_DIGITS = 4,
  parameter int POINTS     = 1
) (
  input logic               clk,
  input logic               reset,
  score_bcd_counter_if.slave bus
);
  localparam int W = NUM_DIGITS * 4;
  localparam logic [W-1:0] ALL_NINES = {NUM_DIGITS{4'h9}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAYING,
    S_OVER
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] score_q, score_d;
  logic [W-1:0] high_q, high_d;
  logic [W-1:0] digits_q, digits_d;
  logic         playing_q, playing_d;
  logic         new_high_q, new_high_d;
  logic [W-1:0] score_inc;

  // Decimal ripple add of POINTS; a carry out of the top digit saturates.
  always_comb begin : bcd_add
    logic [4:0] sum;
    logic       carry;
    sum       = '0;
    carry     = 1'b0;
    score_inc = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      sum = {1'b0, score_q[i*4 +: 4]} + {4'd0, carry};
      if (i == 0) sum = sum + 5'(POINTS);
      if (sum > 5'd9) begin
        score_inc[i*4 +: 4] = 4'(sum - 5'd10);
        carry               = 1'b1;
      end else begin
        score_inc[i*4 +: 4] = sum[3:0];
        carry               = 1'b0;
      end
    end
    if (carry) score_inc = ALL_NINES;
  end

  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    high_d     = high_q;
    new_high_d = new_high_q;
    if (bus.start) begin
      state_d    = S_PLAYING;
      score_d    = '0;
      new_high_d = 1'b0;
    end else begin
      case (state_q)
        S_PLAYING: begin
          if (bus.game_over) begin
            state_d = S_OVER;
            // Valid BCD packed MSD-first orders the same as plain binary.
            if (score_q > high_q) begin
              high_d     = score_q;
              new_high_d = 1'b1;
            end else begin
              new_high_d = 1'b0;
            end
          end else if (bus.eat) begin
            score_d = score_inc;
          end
        end
        default: ;
      endcase
    end
    playing_d = (state_d == S_PLAYING);
    digits_d  = bus.show_high ? high_d : score_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      score_q    <= '0;
      high_q     <= '0;
      digits_q   <= '0;
      playing_q  <= 1'b0;
      new_high_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      score_q    <= score_d;
      high_q     <= high_d;
      digits_q   <= digits_d;
      playing_q  <= playing_d;
      new_high_q <= new_high_d;
    end
  end

  assign bus.digits   = digits_q;
  assign bus.playing  = playing_q;
  assign bus.new_high = new_high_q;
endmodule

// File: tb/tb_score_bcd_counter.sv
// Directed bench: POINTS=1 instance for game flow, POINTS=9 instance for saturation.
module tb_score_bcd_counter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  score_bcd_counter_if #(.NUM_DIGITS(4)) b0 ();
  score_bcd_counter_if #(.NUM_DIGITS(4)) b9 ();

  score_bcd_counter #(.NUM_DIGITS(4), .POINTS(1)) u0 (.clk(clk), .reset(reset), .bus(b0.slave));
  score_bcd_counter #(.NUM_DIGITS(4), .POINTS(9)) u9 (.clk(clk), .reset(reset), .bus(b9.slave));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic eat0(input int n);
    for (int i = 0; i < n; i++) begin
      b0.eat = 1'b1;
      cyc();
    end
    b0.eat = 1'b0;
  endtask

  task automatic start0();
    b0.start = 1'b1;
    cyc();
    b0.start = 1'b0;
  endtask

  task automatic over0();
    b0.game_over = 1'b1;
    cyc();
    b0.game_over = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    checks++; if (b0.digits !== 16'h0000 || b0.playing !== 1'b0 || b0.new_high !== 1'b0) begin
      errors++; $display("FAIL reset_state digits=%h playing=%b new_high=%b want 0000/0/0", b0.digits, b0.playing, b0.new_high);
    end
    reset = 1'b0;
    eat0(3);
    b0.game_over = 1'b1; cyc(); b0.game_over = 1'b0;
    checks++; if (b0.digits !== 16'h0000 || b0.playing !== 1'b0 || b0.new_high !== 1'b0) begin
      errors++; $display("FAIL idle_ignore digits=%h playing=%b new_high=%b want 0000/0/0", b0.digits, b0.playing, b0.new_high);
    end
  endtask

  task automatic test_count();
    start0();
    checks++; if (b0.playing !== 1'b1 || b0.digits !== 16'h0000) begin
      errors++; $display("FAIL start playing=%b digits=%h want 1/0000", b0.playing, b0.digits);
    end
    eat0(1);
    checks++; if (b0.digits !== 16'h0001) begin
      errors++; $display("FAIL first_eat digits=%h want 0001", b0.digits);
    end
    eat0(9);
    checks++; if (b0.digits !== 16'h0010) begin
      errors++; $display("FAIL carry_10 digits=%h want 0010", b0.digits);
    end
    eat0(89);
    checks++; if (b0.digits !== 16'h0099) begin
      errors++; $display("FAIL count_99 digits=%h want 0099", b0.digits);
    end
    eat0(1);
    checks++; if (b0.digits !== 16'h0100) begin
      errors++; $display("FAIL carry_100 digits=%h want 0100", b0.digits);
    end
  endtask

  task automatic test_saturation();
    b9.start = 1'b1; cyc(); b9.start = 1'b0;
    b9.eat = 1'b1; cyc();
    checks++; if (b9.digits !== 16'h0009) begin
      errors++; $display("FAIL p9_one digits=%h want 0009", b9.digits);
    end
    cyc();
    checks++; if (b9.digits !== 16'h0018) begin
      errors++; $display("FAIL p9_two digits=%h want 0018", b9.digits);
    end
    for (int i = 0; i < 1109; i++) cyc();
    b9.eat = 1'b0;
    checks++; if (b9.digits !== 16'h9999) begin
      errors++; $display("FAIL p9_full digits=%h want 9999", b9.digits);
    end
    b9.eat = 1'b1; cyc(); cyc(); b9.eat = 1'b0;
    checks++; if (b9.digits !== 16'h9999) begin
      errors++; $display("FAIL saturate digits=%h want 9999", b9.digits);
    end
  endtask

  task automatic test_high_score();
    start0();
    eat0(25);
    over0();
    checks++; if (b0.new_high !== 1'b1 || b0.playing !== 1'b0 || b0.digits !== 16'h0025) begin
      errors++; $display("FAIL game1_over new_high=%b playing=%b digits=%h want 1/0/0025", b0.new_high, b0.playing, b0.digits);
    end
    eat0(2);
    b0.show_high = 1'b1; cyc();
    checks++; if (b0.digits !== 16'h0025) begin
      errors++; $display("FAIL game1_high digits=%h want 0025", b0.digits);
    end
    b0.show_high = 1'b0; cyc();
    start0();
    checks++; if (b0.new_high !== 1'b0 || b0.digits !== 16'h0000) begin
      errors++; $display("FAIL game2_start new_high=%b digits=%h want 0/0000", b0.new_high, b0.digits);
    end
    eat0(25);
    over0();
    b0.show_high = 1'b1; cyc();
    checks++; if (b0.new_high !== 1'b0 || b0.digits !== 16'h0025) begin
      errors++; $display("FAIL game2_equal new_high=%b high=%h want 0/0025", b0.new_high, b0.digits);
    end
    b0.show_high = 1'b0;
    start0();
    eat0(30);
    over0();
    b0.show_high = 1'b1; cyc();
    checks++; if (b0.new_high !== 1'b1 || b0.digits !== 16'h0030) begin
      errors++; $display("FAIL game3_high new_high=%b high=%h want 1/0030", b0.new_high, b0.digits);
    end
    b0.show_high = 1'b0; cyc();
    checks++; if (b0.digits !== 16'h0030) begin
      errors++; $display("FAIL game3_score digits=%h want 0030", b0.digits);
    end
  endtask

  task automatic test_simultaneous();
    start0();
    eat0(7);
    b0.eat = 1'b1; b0.game_over = 1'b1; cyc(); b0.eat = 1'b0; b0.game_over = 1'b0;
    checks++; if (b0.playing !== 1'b0 || b0.digits !== 16'h0007 || b0.new_high !== 1'b0) begin
      errors++; $display("FAIL eat_go playing=%b digits=%h new_high=%b want 0/0007/0", b0.playing, b0.digits, b0.new_high);
    end
    b0.show_high = 1'b1; cyc(); b0.show_high = 1'b0;
    checks++; if (b0.digits !== 16'h0030) begin
      errors++; $display("FAIL low_no_update high=%h want 0030", b0.digits);
    end
    b0.start = 1'b1; b0.eat = 1'b1; b0.game_over = 1'b1; cyc();
    b0.start = 1'b0; b0.eat = 1'b0; b0.game_over = 1'b0;
    checks++; if (b0.playing !== 1'b1 || b0.digits !== 16'h0000) begin
      errors++; $display("FAIL start_eat playing=%b digits=%h want 1/0000", b0.playing, b0.digits);
    end
    eat0(2);
    b0.start = 1'b1; b0.eat = 1'b1; cyc(); b0.start = 1'b0; b0.eat = 1'b0;
    checks++; if (b0.playing !== 1'b1 || b0.digits !== 16'h0000) begin
      errors++; $display("FAIL restart playing=%b digits=%h want 1/0000", b0.playing, b0.digits);
    end
  endtask

  task automatic test_reset_mid();
    eat0(42);
    checks++; if (b0.digits !== 16'h0042) begin
      errors++; $display("FAIL pre_reset digits=%h want 0042", b0.digits);
    end
    reset = 1'b1; cyc(); reset = 1'b0;
    checks++; if (b0.digits !== 16'h0000 || b0.playing !== 1'b0 || b0.new_high !== 1'b0) begin
      errors++; $display("FAIL mid_reset digits=%h playing=%b new_high=%b want 0000/0/0", b0.digits, b0.playing, b0.new_high);
    end
    b0.show_high = 1'b1; cyc(); b0.show_high = 1'b0;
    checks++; if (b0.digits !== 16'h0000) begin
      errors++; $display("FAIL high_lost high=%h want 0000", b0.digits);
    end
    start0();
    eat0(1);
    over0();
    checks++; if (b0.new_high !== 1'b1 || b0.digits !== 16'h0001) begin
      errors++; $display("FAIL post_reset_game new_high=%b digits=%h want 1/0001", b0.new_high, b0.digits);
    end
  endtask

  initial begin
    b0.start = 1'b0; b0.eat = 1'b0; b0.game_over = 1'b0; b0.show_high = 1'b0;
    b9.start = 1'b0; b9.eat = 1'b0; b9.game_over = 1'b0; b9.show_high = 1'b0;
    test_reset();
    test_count();
    test_saturation();
    test_high_score();
    test_simultaneous();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
